fetch_stage: RTL and testbench

- Instruction fetch stage directly upstream of the decode stage; its registered outputs drive the decode stage's fetch fields (pc, instr, exception, ecause, etval).
- Issues word-aligned instruction-memory requests and buffers returned words in a small FIFO.
- Realigns mixed 16-bit (RV32C) and 32-bit instructions, including 32-bit instructions that straddle a word boundary.
- Handles redirects (jump/trap/mret) and pipeline stalls.

---
 rtl/fetch_stage.sv | 203 ++++++++++++++++++++
 tb/tb_fetch_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: word-aligned imem requests, small word FIFO, and an
// RV32C realigner feeding registered pc/instr/fault fields to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_valid,
  output logic [31:0] imem_addr,
  output logic        imem_instr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        imem_error,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        stall,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_exception,
  output logic [3:0]  f_ecause,
  output logic [31:0] f_etval
);

  // state | meaning
  // RUN   | fetching and aligning
  // HALT  | fault delivered; idle until redirect
  typedef enum logic {RUN, HALT} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t state, state_nxt;

  logic [31:0] faddr;
  logic [31:0] req_addr;
  logic        busy;
  logic        discard;
  logic        skip_pend;
  logic [31:0] pc;
  logic [15:0] res;
  logic        rv;

  logic [31:0] fifo_data [DEPTH];
  logic        fifo_err  [DEPTH];
  logic        fifo_skip [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  logic        accept, push, pop;
  logic        head_vld, head_err, head_skip;
  logic [31:0] head_data;
  logic        emit, fault;
  logic [31:0] emit_instr;
  logic [2:0]  pc_step;
  logic [15:0] res_nxt;
  logic        rv_nxt;

  assign imem_instr = 1'b1;
  // A held request stays up even after a redirect so its stale response can be drained.
  assign imem_valid = reset & (busy | ((state == RUN) & ~discard & (count < CW'(DEPTH))));
  assign imem_addr  = busy ? req_addr : faddr;
  assign accept     = imem_valid & imem_ready;
  assign push       = accept & ~discard & ~redirect & (state == RUN);

  assign head_vld  = (count != '0);
  assign head_data = fifo_data[rptr];
  assign head_err  = fifo_err[rptr];
  assign head_skip = fifo_skip[rptr];

  always_comb begin
    emit       = 1'b0;
    fault      = 1'b0;
    emit_instr = '0;
    pop        = 1'b0;
    pc_step    = 3'd0;
    res_nxt    = res;
    rv_nxt     = rv;
    if (state == RUN && !stall) begin
      if (!rv) begin
        if (head_vld) begin
          pop = 1'b1;
          if (head_err) begin
            emit  = 1'b1;
            fault = 1'b1;
          end else if (head_skip) begin
            res_nxt = head_data[31:16];
            rv_nxt  = 1'b1;
          end else if (head_data[1:0] != 2'b11) begin
            emit       = 1'b1;
            emit_instr = {16'h0, head_data[15:0]};
            res_nxt    = head_data[31:16];
            rv_nxt     = 1'b1;
            pc_step    = 3'd2;
          end else begin
            emit       = 1'b1;
            emit_instr = head_data;
            pc_step    = 3'd4;
          end
        end
      end else if (res[1:0] != 2'b11) begin
        emit       = 1'b1;
        emit_instr = {16'h0, res};
        rv_nxt     = 1'b0;
        pc_step    = 3'd2;
      end else if (head_vld) begin
        // Straddling 32-bit instruction: low half is the residual.
        pop = 1'b1;
        if (head_err) begin
          emit  = 1'b1;
          fault = 1'b1;
        end else begin
          emit       = 1'b1;
          emit_instr = {head_data[15:0], res};
          res_nxt    = head_data[31:16];
          pc_step    = 3'd4;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (redirect) state_nxt = RUN;
    else if (fault) state_nxt = HALT;
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wptr] <= imem_rdata;
      fifo_err[wptr]  <= imem_error;
      fifo_skip[wptr] <= skip_pend;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      faddr       <= RESET_PC & ~32'h3;
      req_addr    <= '0;
      busy        <= 1'b0;
      discard     <= 1'b0;
      skip_pend   <= 1'b0;
      pc          <= RESET_PC;
      res         <= '0;
      rv          <= 1'b0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      f_valid     <= 1'b0;
      f_pc        <= '0;
      f_instr     <= '0;
      f_exception <= 1'b0;
      f_ecause    <= '0;
      f_etval     <= '0;
    end else begin
      busy     <= imem_valid & ~imem_ready;
      req_addr <= imem_addr;
      if (redirect) begin
        faddr       <= redirect_addr & ~32'h3;
        discard     <= imem_valid & ~imem_ready;
        skip_pend   <= redirect_addr[1];
        pc          <= redirect_addr & ~32'h1;
        rv          <= 1'b0;
        wptr        <= '0;
        rptr        <= '0;
        count       <= '0;
        f_valid     <= 1'b0;
        f_pc        <= '0;
        f_instr     <= '0;
        f_exception <= 1'b0;
        f_ecause    <= '0;
        f_etval     <= '0;
      end else begin
        if (accept && discard) discard <= 1'b0;
        if (push) begin
          wptr      <= wptr + AW'(1);
          faddr     <= faddr + 32'd4;
          skip_pend <= 1'b0;
        end
        if (pop) rptr <= rptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
        res   <= res_nxt;
        rv    <= rv_nxt;
        pc    <= pc + {29'd0, pc_step};
        if (!stall) begin
          f_valid     <= emit;
          f_pc        <= emit ? pc : 32'h0;
          f_instr     <= emit_instr;
          f_exception <= fault;
          f_ecause    <= fault ? 4'd1 : 4'd0;
          f_etval     <= fault ? pc : 32'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: randomized memory/stall/redirect traffic scored against a
// halfword-addressed instruction-stream model, plus directed scenarios.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h100;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_valid, imem_instr, imem_ready, imem_error;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect, stall;
  logic [31:0] redirect_addr;
  logic        f_valid, f_exception;
  logic [31:0] f_pc, f_instr, f_etval;
  logic [3:0]  f_ecause;

  always #5 clock = ~clock;

  fetch_stage #(.RESET_PC(RST_PC), .DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .imem_error(imem_error),
    .redirect(redirect), .redirect_addr(redirect_addr), .stall(stall),
    .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr), .f_exception(f_exception),
    .f_ecause(f_ecause), .f_etval(f_etval)
  );

  int n_vec = 0, n_err = 0, n_consumed = 0;
  logic [31:0] mem [logic [31:0]];
  bit          merr [logic [31:0]];
  int rand_err_pct = 0, max_lat = 0, lat_cnt = 0;
  logic [31:0] exp_pc;
  bit halted = 0, post_redir = 0, hold_chk = 0, pend_chk = 0;
  logic [31:0] pend_addr, snap_pc, snap_instr, snap_etval;
  logic [5:0]  snap_ctl;
  logic [31:0] resp_log[$], cons_pc[$], cons_instr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void touch(input logic [31:0] wa);
    if (!mem.exists(wa)) begin
      mem[wa]  = $urandom;
      merr[wa] = ($urandom_range(0, 99) < rand_err_pct);
    end
  endfunction

  // Next instruction from the halfword stream at exp_pc.
  task automatic model_next(output logic [31:0] instr, output logic [2:0] len, output bit flt);
    logic [31:0] wa0, wa1, a2, w0, w1;
    logic [15:0] h0, h1;
    wa0 = exp_pc & ~32'h3;
    touch(wa0);
    w0  = mem[wa0];
    h0  = exp_pc[1] ? w0[31:16] : w0[15:0];
    flt = merr[wa0];
    instr = 32'h0;
    len = 3'd2;
    if (!flt) begin
      if (h0[1:0] != 2'b11) begin
        instr = {16'h0, h0};
      end else begin
        a2  = exp_pc + 32'd2;
        wa1 = a2 & ~32'h3;
        touch(wa1);
        w1  = mem[wa1];
        h1  = a2[1] ? w1[31:16] : w1[15:0];
        if (merr[wa1]) flt = 1;
        else begin
          instr = {h1, h0};
          len = 3'd4;
        end
      end
    end
  endtask

  task automatic respond();
    logic [31:0] wa;
    imem_ready = 1'b0;
    imem_error = 1'b0;
    imem_rdata = $urandom;
    if (!reset) begin
      pend_chk = 0;
    end else begin
      if (pend_chk) begin
        chk("req_held_valid", {31'b0, imem_valid}, 32'd1);
        chk("req_held_addr", imem_addr, pend_addr);
      end
      if (imem_valid) begin
        chk("addr_aligned", {30'b0, imem_addr[1:0]}, 32'd0);
        if (lat_cnt == 0) begin
          wa = imem_addr;
          touch(wa);
          imem_ready = 1'b1;
          imem_rdata = mem[wa];
          imem_error = merr[wa];
          resp_log.push_back(wa);
          lat_cnt = $urandom_range(0, max_lat);
        end else begin
          lat_cnt--;
        end
      end
      pend_chk = imem_valid && !imem_ready;
      pend_addr = imem_addr;
    end
  endtask

  // Score the cycle about to be clocked, then advance to the next negedge.
  task automatic tick();
    logic [31:0] e_instr;
    logic [2:0]  e_len;
    bit          e_flt;
    if (!reset) begin
      exp_pc = RST_PC; halted = 0; post_redir = 0; hold_chk = 0;
    end else begin
      if (hold_chk) begin
        chk("stall_hold_pc", f_pc, snap_pc);
        chk("stall_hold_instr", f_instr, snap_instr);
        chk("stall_hold_etval", f_etval, snap_etval);
        chk("stall_hold_ctl", {26'b0, f_valid, f_exception, f_ecause}, {26'b0, snap_ctl});
      end
      if (post_redir) chk("redirect_bubble", {31'b0, f_valid}, 32'd0);
      post_redir = 0;
      if (redirect) begin
        exp_pc = redirect_addr & ~32'h1;
        halted = 0;
        post_redir = 1;
      end else if (f_valid && !stall) begin
        if (halted) begin
          chk("valid_while_halted", {31'b0, f_valid}, 32'd0);
        end else begin
          model_next(e_instr, e_len, e_flt);
          chk("f_pc", f_pc, exp_pc);
          chk("f_exception", {31'b0, f_exception}, {31'b0, e_flt});
          if (e_flt) begin
            chk("f_ecause", {28'b0, f_ecause}, 32'd1);
            chk("f_etval", f_etval, exp_pc);
            chk("f_instr_fault", f_instr, 32'h0);
            halted = 1;
          end else begin
            chk("f_instr", f_instr, e_instr);
            exp_pc = exp_pc + {29'b0, e_len};
          end
          cons_pc.push_back(f_pc);
          cons_instr.push_back(f_instr);
          n_consumed++;
        end
      end
      hold_chk = stall && !redirect;
      snap_pc = f_pc; snap_instr = f_instr; snap_etval = f_etval;
      snap_ctl = {f_valid, f_exception, f_ecause};
    end
    @(posedge clock);
    @(negedge clock);
    respond();
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect = 1'b1;
    redirect_addr = a;
    tick();
    redirect = 1'b0;
    cons_pc.delete();
    cons_instr.delete();
  endtask

  initial begin
    bit found;
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_addr = '0;
    imem_ready = 1'b0; imem_error = 1'b0; imem_rdata = '0;
    mem[32'h100] = 32'h0000_0013; merr[32'h100] = 0;
    mem[32'h104] = 32'h0000_0093; merr[32'h104] = 0;

    repeat (3) tick();
    chk("rst_imem_valid", {31'b0, imem_valid}, 32'd0);
    chk("rst_f_valid", {31'b0, f_valid}, 32'd0);
    chk("rst_f_pc", f_pc, 32'h0);
    chk("rst_f_instr", f_instr, 32'h0);
    chk("rst_f_exception", {31'b0, f_exception}, 32'd0);
    chk("imem_instr", {31'b0, imem_instr}, 32'd1);

    // Reset fetch, zero wait states
    resp_log.delete();
    reset = 1'b1;
    repeat (12) tick();
    chk("req_cnt", {31'b0, resp_log.size() >= 3}, 32'd1);
    if (resp_log.size() >= 3) begin
      chk("req_addr0", resp_log[0], 32'h100);
      chk("req_addr1", resp_log[1], 32'h104);
      chk("req_addr2", resp_log[2], 32'h108);
    end
    chk("cons_cnt1", {31'b0, cons_pc.size() >= 2}, 32'd1);
    if (cons_pc.size() >= 2) begin
      chk("first_pc", cons_pc[0], 32'h100);
      chk("first_instr", cons_instr[0], 32'h13);
      chk("second_pc", cons_pc[1], 32'h104);
      chk("second_instr", cons_instr[1], 32'h93);
    end

    // Two compressed in one word
    mem[32'h200] = 32'h4501_4505; merr[32'h200] = 0;
    redirect_to(32'h200);
    repeat (8) tick();
    chk("cons_cnt2", {31'b0, cons_pc.size() >= 2}, 32'd1);
    if (cons_pc.size() >= 2) begin
      chk("c0_instr", cons_instr[0], 32'h4505);
      chk("c1_pc", cons_pc[1], 32'h202);
      chk("c1_instr", cons_instr[1], 32'h4501);
    end

    // Straddling 32-bit instruction
    mem[32'h300] = 32'h0013_4505; merr[32'h300] = 0;
    mem[32'h304] = 32'h1234_0000; merr[32'h304] = 0;
    redirect_to(32'h300);
    repeat (10) tick();
    chk("cons_cnt3", {31'b0, cons_pc.size() >= 3}, 32'd1);
    if (cons_pc.size() >= 3) begin
      chk("straddle_pc", cons_pc[1], 32'h302);
      chk("straddle_instr", cons_instr[1], 32'h13);
      chk("resid_pc", cons_pc[2], 32'h306);
      chk("resid_instr", cons_instr[2], 32'h1234);
    end

    // Redirect with an outstanding request, odd halfword target
    max_lat = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (imem_valid && !imem_ready && lat_cnt > 0) found = 1;
    end
    chk("outstanding_found", {31'b0, found}, 32'd1);
    mem[32'h400] = 32'h4505_0013; merr[32'h400] = 0;
    resp_log.delete();
    redirect_to(32'h402);
    repeat (20) tick();
    chk("resp_cnt4", {31'b0, resp_log.size() >= 2}, 32'd1);
    if (resp_log.size() >= 2) chk("refetch_addr", resp_log[1], 32'h400);
    chk("cons_cnt4", {31'b0, cons_pc.size() >= 1}, 32'd1);
    if (cons_pc.size() >= 1) begin
      chk("skip_pc", cons_pc[0], 32'h402);
      chk("skip_instr", cons_instr[0], 32'h4505);
    end

    // Access fault
    max_lat = 1;
    mem[32'h500] = 32'h0000_0013; merr[32'h500] = 1;
    redirect_to(32'h500);
    for (int i = 0; i < 40 && !halted; i++) tick();
    chk("fault_seen", {31'b0, halted}, 32'd1);
    repeat (6) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt_no_req", {31'b0, imem_valid}, 32'd0);
      chk("halt_no_out", {31'b0, f_valid}, 32'd0);
    end

    // Stall mid-stream until the FIFO fills
    max_lat = 0;
    redirect_to(32'h600);
    repeat (6) tick();
    stall = 1'b1;
    repeat (6) tick();
    chk("full_no_req", {31'b0, imem_valid}, 32'd0);
    stall = 1'b0;
    repeat (12) tick();

    // Randomized traffic
    rand_err_pct = 3;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) max_lat = $urandom_range(0, 3);
      if ($urandom_range(0, 59) == 0 || (halted && $urandom_range(0, 3) == 0))
        redirect_to($urandom & 32'h0000_3FFF);
      else
        tick();
    end
    stall = 1'b0;
    repeat (4) tick();
    chk("consumed_min", {31'b0, n_consumed > 300}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
